// File: rtl/ram_burst_interface.sv
// Cache-line burst engine: line fill, line write-back, or write-back followed by fill over a narrow RAM bus.
// Define RAM_BURST_TIMEOUT_EN to build the per-beat RAM_ACK timeout (ERR is tied low otherwise).
module ram_burst_interface #(
    parameter int ADDR_SIZE = 20,
    parameter int LINE_SIZE = 128,
    parameter int BUS_SIZE  = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SIG_RAM_RD,
    input  logic                 SIG_RAM_WR,
    input  logic [ADDR_SIZE-1:0] IN_ADDR,
    input  logic [ADDR_SIZE-1:0] IN_WB_ADDR,
    input  logic [LINE_SIZE-1:0] IN_LINE,
    output logic [LINE_SIZE-1:0] OUT_LINE,
    output logic                 OUT_ACK,
    output logic                 BUSY,
    output logic                 ERR,
    input  logic [BUS_SIZE-1:0]  RAM_IN_DATA,
    input  logic                 RAM_ACK,
    output logic [BUS_SIZE-1:0]  RAM_OUT_DATA,
    output logic [ADDR_SIZE-1:0] RAM_ADDR,
    output logic                 RAM_REQ,
    output logic                 RAM_READ_NOT_WRITE,
    output logic [1:0]           dbg_state
);

    localparam int BEATS = LINE_SIZE / BUS_SIZE;
    localparam int BW    = $clog2(BEATS);
    localparam int HW    = ADDR_SIZE - BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || BEATS * BUS_SIZE != LINE_SIZE || TIMEOUT < 1)
    begin : g_bad_params
        $error("ram_burst_interface: illegal LINE_SIZE/BUS_SIZE ratio or TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state;
    logic [BW-1:0]                 beat;
    logic [BW-1:0]                 beat_nxt;
    logic [HW-1:0]                 wb_base;
    logic [HW-1:0]                 fill_base;
    logic [LINE_SIZE-1:0]          wb_rest;
    logic [LINE_SIZE-BUS_SIZE-1:0] shadow;
    logic [LINE_SIZE-1:0]          fill_line;
    logic                          fill_pending;
    logic                          timeout_hit;
    logic                          unused_addr_bits;

    assign beat_nxt         = beat + 1'b1;
    assign fill_line        = {RAM_IN_DATA, shadow};
    assign dbg_state        = state;
    assign unused_addr_bits = ^{IN_ADDR[BW-1:0], IN_WB_ADDR[BW-1:0]};

    // Beat handshake: while RAM_REQ is high, RAM_ADDR, RAM_OUT_DATA and RAM_READ_NOT_WRITE are held
    // until RAM_ACK is sampled high on a rising edge; the next beat follows on the very next cycle.
    // The first cycle in WB/FILL after a request is a launch cycle with RAM_REQ still low, so ACK is
    // only ever honoured while RAM_REQ is high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state              <= IDLE;
            beat               <= '0;
            wb_base            <= '0;
            fill_base          <= '0;
            wb_rest            <= '0;
            shadow             <= '0;
            fill_pending       <= 1'b0;
            OUT_LINE           <= '0;
            OUT_ACK            <= 1'b0;
            BUSY               <= 1'b0;
            RAM_REQ            <= 1'b0;
            RAM_READ_NOT_WRITE <= 1'b0;
            RAM_ADDR           <= '0;
            RAM_OUT_DATA       <= '0;
        end else begin
            OUT_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (SIG_RAM_WR) begin
                        wb_base            <= IN_WB_ADDR[ADDR_SIZE-1:BW];
                        fill_base          <= IN_ADDR[ADDR_SIZE-1:BW];
                        fill_pending       <= SIG_RAM_RD;
                        wb_rest            <= IN_LINE >> BUS_SIZE;
                        beat               <= '0;
                        RAM_READ_NOT_WRITE <= 1'b0;
                        RAM_ADDR           <= {IN_WB_ADDR[ADDR_SIZE-1:BW], {BW{1'b0}}};
                        RAM_OUT_DATA       <= IN_LINE[BUS_SIZE-1:0];
                        BUSY               <= 1'b1;
                        state              <= WB;
                    end else if (SIG_RAM_RD) begin
                        fill_base          <= IN_ADDR[ADDR_SIZE-1:BW];
                        fill_pending       <= 1'b0;
                        beat               <= '0;
                        RAM_READ_NOT_WRITE <= 1'b1;
                        RAM_ADDR           <= {IN_ADDR[ADDR_SIZE-1:BW], {BW{1'b0}}};
                        BUSY               <= 1'b1;
                        state              <= FILL;
                    end
                end
                WB: begin
                    if (!RAM_REQ) begin
                        RAM_REQ <= 1'b1;
                    end else if (timeout_hit) begin
                        RAM_REQ <= 1'b0;
                        OUT_ACK <= 1'b1;
                        beat    <= '0;
                        state   <= DONE;
                    end else if (RAM_ACK) begin
                        if (beat == LAST_BEAT) begin
                            beat <= '0;
                            if (fill_pending) begin
                                RAM_READ_NOT_WRITE <= 1'b1;
                                RAM_ADDR           <= {fill_base, {BW{1'b0}}};
                                state              <= FILL;
                            end else begin
                                RAM_REQ <= 1'b0;
                                OUT_ACK <= 1'b1;
                                state   <= DONE;
                            end
                        end else begin
                            beat         <= beat_nxt;
                            RAM_ADDR     <= {wb_base, beat_nxt};
                            RAM_OUT_DATA <= wb_rest[BUS_SIZE-1:0];
                            wb_rest      <= wb_rest >> BUS_SIZE;
                        end
                    end
                end
                FILL: begin
                    if (!RAM_REQ) begin
                        RAM_REQ <= 1'b1;
                    end else if (timeout_hit) begin
                        RAM_REQ <= 1'b0;
                        OUT_ACK <= 1'b1;
                        beat    <= '0;
                        state   <= DONE;
                    end else if (RAM_ACK) begin
                        // Beats shift in from the top, so beat 0 ends up in the lowest slot.
                        shadow <= fill_line[LINE_SIZE-1:BUS_SIZE];
                        if (beat == LAST_BEAT) begin
                            beat     <= '0;
                            OUT_LINE <= fill_line;
                            RAM_REQ  <= 1'b0;
                            OUT_ACK  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            beat     <= beat_nxt;
                            RAM_ADDR <= {fill_base, beat_nxt};
                        end
                    end
                end
                DONE: begin
                    BUSY         <= 1'b0;
                    fill_pending <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Fires on the TIMEOUT-th consecutive unacknowledged cycle of a beat.
    assign timeout_hit = RAM_REQ && !RAM_ACK && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= '0;
            ERR      <= 1'b0;
        end else begin
            ERR <= timeout_hit;
            if (!RAM_REQ || RAM_ACK || timeout_hit) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_ram_burst_interface.sv
// Self-checking bench for ram_burst_interface: directed test-plan cases plus randomized bursts
// checked every cycle against a queue-based beat model.
module tb_ram_burst_interface;

  localparam int AW    = 20;
  localparam int LW    = 128;
  localparam int BUS   = 16;
  localparam int BEATS = LW / BUS;
  localparam int TO    = 4;
  localparam int EW    = 1 + AW + BUS;
  localparam logic [LW-1:0] FILL_LINE = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
  localparam logic [LW-1:0] WB_LINE   = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  // clock / reset and DUT signals
  logic          CLK;
  logic          RESET;
  logic          SIG_RAM_RD;
  logic          SIG_RAM_WR;
  logic [AW-1:0] IN_ADDR;
  logic [AW-1:0] IN_WB_ADDR;
  logic [LW-1:0] IN_LINE;
  logic [LW-1:0] OUT_LINE;
  logic          OUT_ACK;
  logic          BUSY;
  logic          ERR;
  logic [BUS-1:0] RAM_IN_DATA;
  logic          RAM_ACK;
  logic [BUS-1:0] RAM_OUT_DATA;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_REQ;
  logic          RAM_READ_NOT_WRITE;
  logic [1:0]    dbg_state;

  ram_burst_interface #(
    .ADDR_SIZE(AW),
    .LINE_SIZE(LW),
    .BUS_SIZE (BUS),
    .TIMEOUT  (TO)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .SIG_RAM_RD        (SIG_RAM_RD),
    .SIG_RAM_WR        (SIG_RAM_WR),
    .IN_ADDR           (IN_ADDR),
    .IN_WB_ADDR        (IN_WB_ADDR),
    .IN_LINE           (IN_LINE),
    .OUT_LINE          (OUT_LINE),
    .OUT_ACK           (OUT_ACK),
    .BUSY              (BUSY),
    .ERR               (ERR),
    .RAM_IN_DATA       (RAM_IN_DATA),
    .RAM_ACK           (RAM_ACK),
    .RAM_OUT_DATA      (RAM_OUT_DATA),
    .RAM_ADDR          (RAM_ADDR),
    .RAM_REQ           (RAM_REQ),
    .RAM_READ_NOT_WRITE(RAM_READ_NOT_WRITE),
    .dbg_state         (dbg_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int b);
    beat_addr = (base & ~AW'(BEATS - 1)) | AW'(b);
  endfunction

  // Behavioural model: the list of beats still owed on the bus, {rnw, addr, wdata}.
  logic [EW-1:0] exp_q[$];
  bit            m_busy   = 1'b0;
  bit            m_launch = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_err    = 1'b0;
  bit            m_fill   = 1'b0;
  int            m_wait   = 0;
  logic [LW-1:0] m_line   = '0;
  logic [LW-1:0] m_acc    = '0;

  always @(posedge CLK or posedge RESET) begin
    logic [EW-1:0] e;
    int slot;
    if (RESET) begin
      exp_q.delete();
      m_busy = 1'b0; m_launch = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_fill = 1'b0; m_wait = 0; m_line = '0; m_acc = '0;
    end else if (m_done) begin
      m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (SIG_RAM_WR || SIG_RAM_RD) begin
        m_busy = 1'b1; m_launch = 1'b1; m_fill = SIG_RAM_RD; m_wait = 0;
        if (SIG_RAM_WR)
          for (int b = 0; b < BEATS; b++)
            exp_q.push_back({1'b0, beat_addr(IN_WB_ADDR, b), IN_LINE[b*BUS +: BUS]});
        if (SIG_RAM_RD)
          for (int b = 0; b < BEATS; b++)
            exp_q.push_back({1'b1, beat_addr(IN_ADDR, b), {BUS{1'b0}}});
      end
    end else if (m_launch) begin
      m_launch = 1'b0;
    end else if (RAM_ACK) begin
      e = exp_q.pop_front();
      if (e[EW-1]) begin
        slot = int'(e[BUS +: 3]);
        m_acc[slot*BUS +: BUS] = RAM_IN_DATA;
      end
      m_wait = 0;
      if (exp_q.size() == 0) begin
        m_done = 1'b1;
        if (m_fill) m_line = m_acc;
      end
    end else begin
      m_wait++;
`ifdef RAM_BURST_TIMEOUT_EN
      if (m_wait == TO) begin
        exp_q.delete();
        m_done = 1'b1;
        m_err  = 1'b1;
        m_wait = 0;
      end
`endif
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    bit exp_req;
    if (chk_en) begin
      exp_req = (exp_q.size() > 0) && !m_launch;
      check("ram_req", LW'(RAM_REQ), LW'(exp_req));
      if (exp_req) begin
        check("ram_addr", LW'(RAM_ADDR), LW'(exp_q[0][BUS +: AW]));
        check("ram_rnw", LW'(RAM_READ_NOT_WRITE), LW'(exp_q[0][EW-1]));
        if (!exp_q[0][EW-1]) check("ram_out_data", LW'(RAM_OUT_DATA), LW'(exp_q[0][BUS-1:0]));
      end
      check("out_ack", LW'(OUT_ACK), LW'(m_done));
      check("busy", LW'(BUSY), LW'(m_busy));
      check("err", LW'(ERR), LW'(m_err));
      check("out_line", OUT_LINE, m_line);
    end
  end

  // RAM responder: 0 = ack always, 1 = ack every third request cycle, 2 = random, 3 = never.
  int ack_mode  = 0;
  bit data_mode = 1'b0;
  int req_cnt   = 0;
  int ack_run   = 0;

  always @(negedge CLK) begin
    if (RAM_REQ) req_cnt++;
    case (ack_mode)
      0:       RAM_ACK = 1'b1;
      1:       RAM_ACK = RAM_REQ && (req_cnt % 3 == 0);
      2:       RAM_ACK = (ack_run >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      default: RAM_ACK = 1'b0;
    endcase
    ack_run = (RAM_REQ && !RAM_ACK) ? ack_run + 1 : 0;
    RAM_IN_DATA = data_mode ? BUS'($urandom) : (16'h1000 + BUS'(RAM_ADDR[2:0]));
  end

  // Driver: issue one request, return the edge index (edge 0 = sampling edge) of OUT_ACK.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [AW-1:0] wa, input logic [LW-1:0] line, output int ack_edge);
    @(negedge CLK);
    SIG_RAM_RD = rd; SIG_RAM_WR = wr;
    IN_ADDR = a; IN_WB_ADDR = wa; IN_LINE = line;
    req_cnt = 0;
    @(posedge CLK);
    #1;
    IN_ADDR = AW'($urandom); IN_WB_ADDR = AW'($urandom);
    IN_LINE = {$urandom, $urandom, $urandom, $urandom};
    ack_edge = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (OUT_ACK) begin
        ack_edge = k;
        break;
      end
    end
    SIG_RAM_RD = 1'b0; SIG_RAM_WR = 1'b0;
    if (ack_edge < 0) check("ack_wait_timeout", LW'(0), LW'(1));
    @(negedge CLK);
    check("ack_single_pulse", LW'(OUT_ACK), LW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ae;
    bit rd;
    bit wr;
    int sel;
    RESET = 1'b1; SIG_RAM_RD = 1'b0; SIG_RAM_WR = 1'b0;
    IN_ADDR = '0; IN_WB_ADDR = '0; IN_LINE = '0;
    RAM_ACK = 1'b0; RAM_IN_DATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_out_line", OUT_LINE, '0);
    check("rst_out_ack", LW'(OUT_ACK), '0);
    check("rst_busy", LW'(BUSY), '0);
    check("rst_err", LW'(ERR), '0);
    check("rst_ram_req", LW'(RAM_REQ), '0);
    check("rst_ram_addr", LW'(RAM_ADDR), '0);
    check("rst_ram_out_data", LW'(RAM_OUT_DATA), '0);
    check("rst_ram_rnw", LW'(RAM_READ_NOT_WRITE), '0);
    chk_en = 1'b1;

    // fill, ack tied high
    ack_mode = 0; data_mode = 1'b0;
    run_txn(1'b1, 1'b0, 20'h00123, 20'h00000, '0, ae);
    check("fill_ack_edge", LW'(ae), LW'(9));
    check("fill_out_line", OUT_LINE, FILL_LINE);

    // write-back only, OUT_LINE must hold
    run_txn(1'b0, 1'b1, 20'h00000, 20'h00040, WB_LINE, ae);
    check("wb_ack_edge", LW'(ae), LW'(9));
    check("wb_out_line_held", OUT_LINE, FILL_LINE);

    // eviction: write-back then fill
    run_txn(1'b1, 1'b1, 20'h00123, 20'h00040, WB_LINE, ae);
    check("evict_ack_edge", LW'(ae), LW'(17));
    check("evict_out_line", OUT_LINE, FILL_LINE);

    // fill with ack every third cycle
    ack_mode = 1;
    run_txn(1'b1, 1'b0, 20'h00123, 20'h00000, '0, ae);
    check("slow_fill_ack_edge", LW'(ae), LW'(25));
    check("slow_fill_out_line", OUT_LINE, FILL_LINE);

`ifdef RAM_BURST_TIMEOUT_EN
    // ack stuck low: abort after TO wait cycles, line untouched
    ack_mode = 3;
    run_txn(1'b1, 1'b0, 20'h00555, 20'h00000, '0, ae);
    check("timeout_ack_edge", LW'(ae), LW'(5));
    check("timeout_out_line_held", OUT_LINE, FILL_LINE);
`endif

    // reset while beat 3 of a fill is on the bus
    ack_mode = 0;
    @(negedge CLK);
    SIG_RAM_RD = 1'b1; IN_ADDR = 20'h00123;
    @(posedge CLK);
    repeat (5) @(negedge CLK);
    check("midrst_beat3_addr", LW'(RAM_ADDR), LW'(20'h00123));
    #2 RESET = 1'b1;
    #1;
    check("midrst_req_drop", LW'(RAM_REQ), '0);
    check("midrst_busy_drop", LW'(BUSY), '0);
    SIG_RAM_RD = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("midrst_no_ack", LW'(OUT_ACK), '0);
    end
    check("midrst_out_line_zero", OUT_LINE, '0);

    // randomized bursts against the model
    ack_mode = 2; data_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(1, 3);
      rd  = sel[0];
      wr  = sel[1];
      run_txn(rd, wr, AW'($urandom), AW'($urandom), {$urandom, $urandom, $urandom, $urandom}, ae);
    end

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_interface.md
# ram_burst_interface

Parametrised single-clock line-transfer engine between the cache controller and external RAM. Moves one cache line of `LINE_SIZE` bits over a narrower `BUS_SIZE`-bit RAM bus as a burst of `BEATS = LINE_SIZE/BUS_SIZE` handshaked beats. Supports line fill, line write-back, and a combined eviction sequence: write-back followed by fill, in one request. Sits between CacheMemory's RAM-side request lines and the RAM bus.

## Interface
- `ADDR_SIZE`, 20, RAM word-address width (one word = `BUS_SIZE` bits)
- `LINE_SIZE`, 128, cache line width in bits
- `BUS_SIZE`, 16, RAM data bus width; `BEATS = LINE_SIZE/BUS_SIZE` must be a power of two, ≥2
- `TIMEOUT`, 255, max cycles per beat waiting for `RAM_ACK`; used only with `RAM_BURST_TIMEOUT_EN`

Ports:
- `CLK` in 1: single clock, rising edge
- `RESET` in 1: asynchronous, active-high reset
- `SIG_RAM_RD` in 1: fill request, level, sampled only in IDLE
- `SIG_RAM_WR` in 1: write-back request, level, sampled only in IDLE
- `IN_ADDR` in `ADDR_SIZE`: fill address; low log2(`BEATS`) bits ignored
- `IN_WB_ADDR` in `ADDR_SIZE`: write-back address; low log2(`BEATS`) bits ignored
- `IN_LINE` in `LINE_SIZE`: line to write back; latched at request
- `OUT_LINE` out `LINE_SIZE`: last successfully filled line
- `OUT_ACK` out 1: one-cycle completion pulse
- `BUSY` out 1: high in every state except IDLE
- `ERR` out 1: one-cycle timeout pulse, coincident with `OUT_ACK`
- `RAM_IN_DATA` in `BUS_SIZE`: read data beat
- `RAM_ACK` in 1: beat acknowledge
- `RAM_OUT_DATA` out `BUS_SIZE`: write data beat
- `RAM_ADDR` out `ADDR_SIZE`: beat word address
- `RAM_REQ` out 1: beat request
- `RAM_READ_NOT_WRITE` out 1: 1 = read beat, 0 = write beat

## Operation
- Reset value of all outputs, including `OUT_LINE`, is 0. State resets to IDLE, beat counter to 0. Reset mid-burst aborts immediately; `RAM_REQ` falls asynchronously and no `OUT_ACK` is issued.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - `SIG_RAM_WR` = 1 → latch `IN_WB_ADDR`, `IN_LINE`, `IN_ADDR`, and `SIG_RAM_RD` as `fill_pending`; go to WB.
  - Otherwise `SIG_RAM_RD` = 1 → latch `IN_ADDR`; go to FILL.
- Beat address: `{base[ADDR_SIZE-1:log2(BEATS)], beat}`. Beat 0 is bits `[BUS_SIZE-1:0]` of the line, little-endian.
- WB: `RAM_REQ` = 1, `RAM_READ_NOT_WRITE` = 0, `RAM_OUT_DATA` = beat slice. On the last beat's ack → FILL if `fill_pending`, else DONE.
- FILL: `RAM_REQ` = 1, `RAM_READ_NOT_WRITE` = 1. On ack, `RAM_IN_DATA` goes into a shadow-line slot. On the last beat's ack → DONE.
- DONE: `OUT_ACK` = 1 for one cycle. `OUT_LINE` is updated from the shadow line if a fill occurred; it holds its value otherwise. Next state is IDLE.
- The cache must drop `SIG_RAM_RD`/`SIG_RAM_WR` before the IDLE cycle following `OUT_ACK`. Requests are ignored while `BUSY`.
- `RAM_ACK` is ignored while `RAM_REQ` = 0.

## Timing
- All outputs are registered.
- Beat handshake:
  - Address, data and direction stay stable while `RAM_REQ` = 1 until `RAM_ACK` = 1 is sampled on a rising edge.
  - The next beat is presented in the following cycle with `RAM_REQ` held high. No idle cycle between beats or between WB and FILL.
- Request sampled at edge 0 → `RAM_REQ` high from edge 1.
- With `RAM_ACK` tied high:
  - Fill or write-back: `OUT_ACK` is high after edge `BEATS`+1, for one cycle.
  - Eviction: `OUT_ACK` is high after edge 2·`BEATS`+1.
- Each wait cycle (ack low) adds one cycle.
- Counter wraps only between phases. It resets to 0 on entry to WB and FILL.

## Configuration
- `RAM_BURST_TIMEOUT_EN` defined:
  - A per-beat counter counts cycles with `RAM_REQ` = 1 and `RAM_ACK` = 0; it clears on every ack.
  - When the counter reaches `TIMEOUT`, the burst aborts: `RAM_REQ` drops next edge and the engine goes to DONE with `ERR` = 1 and `OUT_ACK` = 1.
  - `OUT_LINE` is not updated on abort, and a pending fill is skipped.
- Not defined: the engine waits indefinitely, `ERR` is constant 0, and no counter logic is built.

## Test plan
- Reset asserted for 3 cycles, then released → all outputs 0, `BUSY` = 0.
- Fill, `IN_ADDR` = 0x00123, `RAM_ACK` tied 1, `RAM_IN_DATA` = 0x1000 + beat → `RAM_ADDR` 0x00120..0x00127, `OUT_LINE` = 0x1007_1006_1005_1004_1003_1002_1001_1000, `OUT_ACK` one cycle after edge 9.
- Write-back, `IN_WB_ADDR` = 0x00040, `IN_LINE` = 0x7777_6666_5555_4444_3333_2222_1111_0000 → `RAM_OUT_DATA` 0x0000..0x7777 at 0x00040..0x00047, `RAM_READ_NOT_WRITE` = 0, `OUT_LINE` unchanged.
- Eviction (RD and WR both high), same stimuli as the fill and write-back cases → 8 write beats at 0x00040.., then 8 read beats at 0x00120.., `OUT_ACK` after edge 17, single pulse.
- Fill with `RAM_ACK` high every third cycle → each beat's address is held 3 cycles, `OUT_ACK` after edge 25, same `OUT_LINE` as the fill case.
- Macro on, `TIMEOUT` = 4, `RAM_ACK` stuck 0 → `ERR` and `OUT_ACK` pulse after 4 wait cycles, `OUT_LINE` unchanged. Separately, `RESET` asserted during beat 3 → `RAM_REQ` 0 immediately, no `OUT_ACK`.
